phy_rx_sync_ctrl: RTL

Receive-side link synchronisation controller. It sits directly after the serial-to-parallel deserializer in the PHY and runs on the byte clock. It hunts for COMMA (8'hBC) idle characters and declares the link active after LOCK_COUNT consecutive commas. Once active, it forwards non-comma bytes as valid data, strips idles, and drops back to search when idles stop arriving.

---
 rtl/phy_rx_sync_ctrl_if.sv | 40 ++++
 rtl/phy_rx_sync_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/phy_rx_sync_ctrl_if.sv
// Byte-side bundle between the deserializer/consumer and the receive sync controller.
interface phy_rx_sync_ctrl_if;

  logic       enable;
  logic [7:0] byte_in;
  logic       byte_strobe;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic [3:0] bc_counter;
  logic [1:0] state;
  logic [7:0] resync_count;

  // Upstream side: drives bytes and the run enable, observes link status.
  modport master (
    output enable,
    output byte_in,
    output byte_strobe,
    input  data_out,
    input  valid_out,
    input  active,
    input  bc_counter,
    input  state,
    input  resync_count
  );

  // Controller side.
  modport slave (
    input  enable,
    input  byte_in,
    input  byte_strobe,
    output data_out,
    output valid_out,
    output active,
    output bc_counter,
    output state,
    output resync_count
  );

endinterface

// File: rtl/phy_rx_sync_ctrl.sv
// Receive link sync controller: hunts for comma idles, locks after LOCK_COUNT
// consecutive commas, then forwards data bytes and strips idles until a data
// run longer than MAX_RUN signals loss of alignment.
module phy_rx_sync_ctrl #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned MAX_RUN    = 16
) (
  input  logic                 clk_f,
  input  logic                 reset,
  phy_rx_sync_ctrl_if.slave    sync_if
);

  localparam int unsigned BC_W  = 4;
  localparam int unsigned RUN_W = 8;
  localparam int unsigned CNT_W = 8;

  localparam logic [BC_W-1:0]  LOCK_C   = BC_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] MAX_C    = RUN_W'(MAX_RUN);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  // Reject parameter values outside the range the counters can represent.
  if (LOCK_COUNT < 1 || LOCK_COUNT > 15) begin : g_bad_lock
    $error("phy_rx_sync_ctrl: LOCK_COUNT out of range 1..15");
  end
  if (MAX_RUN < 1 || MAX_RUN > 255) begin : g_bad_run
    $error("phy_rx_sync_ctrl: MAX_RUN out of range 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_LOCKING = 2'd2,
    ST_ACTIVE  = 2'd3
  } state_t;

  state_t             state_q,  state_d;
  logic [BC_W-1:0]    bc_q,     bc_d;
  logic [RUN_W-1:0]   run_q,    run_d;
  logic [7:0]         data_q,   data_d;
  logic               valid_q,  valid_d;
  logic               active_q, active_d;
  logic [CNT_W-1:0]   resync_q, resync_d;

  logic               is_comma;
  logic [BC_W-1:0]    bc_inc;

  assign is_comma = (sync_if.byte_in == COMMA);

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      bc_q     <= '0;
      run_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      resync_q <= '0;
    end else begin
      state_q  <= state_d;
      bc_q     <= bc_d;
      run_q    <= run_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      resync_q <= resync_d;
    end
  end

  // Next-state and next-output logic; enable=0 overrides any byte activity.
  always_comb begin
    state_d  = state_q;
    bc_d     = bc_q;
    run_d    = run_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    resync_d = resync_q;
    bc_inc   = bc_q + BC_W'(1);

    if (!sync_if.enable) begin
      state_d = ST_IDLE;
      bc_d    = '0;
      run_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Bytes arriving in the enable cycle are ignored.
          state_d = ST_SEARCH;
        end

        ST_SEARCH: begin
          if (sync_if.byte_strobe) begin
            if (is_comma) begin
              bc_d    = BC_W'(1);
              state_d = (LOCK_C == BC_W'(1)) ? ST_ACTIVE : ST_LOCKING;
            end else begin
              bc_d = '0;
            end
          end
        end

        ST_LOCKING: begin
          if (sync_if.byte_strobe) begin
            if (is_comma) begin
              bc_d = bc_inc;
              if (bc_inc == LOCK_C) begin
                state_d = ST_ACTIVE;
              end
            end else begin
              // A data byte before lock breaks the streak; it is not forwarded.
              bc_d    = '0;
              state_d = ST_SEARCH;
            end
          end
        end

        ST_ACTIVE: begin
          bc_d = LOCK_C;
          if (sync_if.byte_strobe) begin
            if (is_comma) begin
              run_d = '0;
            end else if (run_q < MAX_C) begin
              data_d  = sync_if.byte_in;
              valid_d = 1'b1;
              run_d   = run_q + RUN_W'(1);
            end else begin
              // Too many data bytes without an idle: alignment is suspect.
              state_d = ST_SEARCH;
              bc_d    = '0;
              run_d   = '0;
              if (resync_q != CNT_SAT) begin
                resync_d = resync_q + CNT_W'(1);
              end
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          bc_d    = '0;
          run_d   = '0;
        end
      endcase
    end

    active_d = (state_d == ST_ACTIVE);
  end

  assign sync_if.state        = state_q;
  assign sync_if.bc_counter   = bc_q;
  assign sync_if.data_out     = data_q;
  assign sync_if.valid_out    = valid_q;
  assign sync_if.active       = active_q;
  assign sync_if.resync_count = resync_q;

endmodule
